// File: rtl/qpl_pkg.sv
// rtl/qpl_pkg.sv - shared width derivations and reply codes for the dealloc ingress
package qpl_pkg;

   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_ZERO_SIZE = 2'b01;
   localparam logic [1:0] ERR_OOB       = 2'b10;

   function automatic int calc_block_w(input int block_d);
      return $clog2(block_d);
   endfunction

   // Request word is {udata, size (one bit wider than base so a full heap fits), base}
   function automatic int calc_rep_w(input int udata_w, input int block_d);
      return udata_w + 2 * $clog2(block_d) + 1;
   endfunction

endpackage

// File: rtl/qpl_sync_fifo.sv
// rtl/qpl_sync_fifo.sv - first-word-fall-through synchronous queue with wrap-bit pointers
module qpl_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic [CNT_W-1:0] o_cnt
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !empty;

   assign o_vld  = !empty;
   assign o_cnt  = wr_ptr - rd_ptr;
   // Head is read from storage only, so a push into an empty queue shows up a cycle later
   assign o_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
   end

endmodule

// File: rtl/qpl_dealloc_ingress.sv
// rtl/qpl_dealloc_ingress.sv - validates user free requests, queues good ones, replies to bad ones
module qpl_dealloc_ingress
   import qpl_pkg::*;
#(
   parameter int BLOCK_D = 512,
   parameter int UDATA_W = 8,
   parameter int FIFO_D  = 4,
   localparam int BLOCK_W = calc_block_w(BLOCK_D),
   localparam int REP_W   = calc_rep_w(UDATA_W, BLOCK_D),
   localparam int CNT_W   = $clog2(FIFO_D) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_usr_vld,
   input  logic [REP_W-1:0]   i_usr_data,
   output logic               o_usr_rdy,
   output logic               o_req_dealloc_vld,
   output logic [REP_W-1:0]   o_req_dealloc_data,
   input  logic               i_req_dealloc_rdy,
   output logic               o_err_vld,
   output logic [UDATA_W+1:0] o_err_data,
   input  logic               i_err_rdy,
   output logic [CNT_W-1:0]   o_fifo_cnt,
   output logic [15:0]        o_rej_cnt
);

   localparam logic [BLOCK_W+1:0] BLOCK_LIM = (BLOCK_W + 2)'(BLOCK_D);

   logic [BLOCK_W-1:0] req_base;
   logic [BLOCK_W:0]   req_size;
   logic [UDATA_W-1:0] req_udata;
   logic [BLOCK_W+1:0] req_end;
   logic [1:0]         req_code;
   logic               accept;
   logic               push;
   logic               reject;
   logic               fifo_full;
   logic               rdy_en;

   assign req_base  = i_usr_data[BLOCK_W-1:0];
   assign req_size  = i_usr_data[2*BLOCK_W:BLOCK_W];
   assign req_udata = i_usr_data[REP_W-1:2*BLOCK_W+1];
   // Two guard bits keep the end address from wrapping back into range
   assign req_end   = {2'b00, req_base} + {1'b0, req_size};

   always_comb begin
      req_code = ERR_NONE;
      if (req_size == '0)
         req_code = ERR_ZERO_SIZE;
      else if (req_end > BLOCK_LIM)
         req_code = ERR_OOB;
   end

   // Ready ignores the word class so it never depends combinationally on i_usr_data
   assign o_usr_rdy = rdy_en && !fifo_full && (!o_err_vld || i_err_rdy);
   assign accept    = i_usr_vld && o_usr_rdy;
   assign push      = accept && (req_code == ERR_NONE);
   assign reject    = accept && (req_code != ERR_NONE);

   qpl_sync_fifo #(
      .WIDTH (REP_W),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (push),
      .i_push_data (i_usr_data),
      .i_pop       (i_req_dealloc_rdy),
      .o_vld       (o_req_dealloc_vld),
      .o_data      (o_req_dealloc_data),
      .o_full      (fifo_full),
      .o_cnt       (o_fifo_cnt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_en     <= 1'b0;
         o_err_vld  <= 1'b0;
         o_err_data <= '0;
         o_rej_cnt  <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (reject) begin
            o_err_vld  <= 1'b1;
            o_err_data <= {req_udata, req_code};
         end else if (o_err_vld && i_err_rdy) begin
            o_err_vld <= 1'b0;
         end
         if (reject && (o_rej_cnt != 16'hFFFF))
            o_rej_cnt <= o_rej_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_qpl_dealloc_ingress.sv
// tb/tb_qpl_dealloc_ingress.sv - directed table-driven bench for qpl_dealloc_ingress
module tb_qpl_dealloc_ingress;

   logic        clk;
   logic        rst_n;
   logic        usr_vld;
   logic [26:0] usr_data;
   logic        usr_rdy;
   logic        dv;
   logic [26:0] dd;
   logic        drdy;
   logic        ev;
   logic [9:0]  ed;
   logic        erdy;
   logic [2:0]  cnt;
   logic [15:0] rej;

   int checks   = 0;
   int failures = 0;
   int rej_exp  = 0;

   qpl_dealloc_ingress #(
      .BLOCK_D (512),
      .UDATA_W (8),
      .FIFO_D  (4)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_usr_vld          (usr_vld),
      .i_usr_data         (usr_data),
      .o_usr_rdy          (usr_rdy),
      .o_req_dealloc_vld  (dv),
      .o_req_dealloc_data (dd),
      .i_req_dealloc_rdy  (drdy),
      .o_err_vld          (ev),
      .o_err_data         (ed),
      .i_err_rdy          (erdy),
      .o_fifo_cnt         (cnt),
      .o_rej_cnt          (rej)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] base;
      logic [9:0] size;
      logic [7:0] udata;
      logic       ok;
      logic [1:0] code;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [26:0] mk(input logic [7:0] u, input logic [9:0] s, input logic [8:0] b);
      return {u, s, b};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic push_word(input logic [26:0] w);
      @(negedge clk);
      usr_vld  = 1'b1;
      usr_data = w;
   endtask

   initial begin
      logic [26:0] w;
      logic [26:0] wa;
      logic [26:0] wb;

      vecs[0] = '{9'h010, 10'd16,  8'hA5, 1'b1, 2'b00};
      vecs[1] = '{9'h000, 10'd0,   8'h3C, 1'b0, 2'b01};
      vecs[2] = '{9'h1F8, 10'd16,  8'h11, 1'b0, 2'b10};
      vecs[3] = '{9'h1F0, 10'd16,  8'h22, 1'b1, 2'b00};
      vecs[4] = '{9'h000, 10'd512, 8'h33, 1'b1, 2'b00};
      vecs[5] = '{9'h1FF, 10'd1,   8'h44, 1'b1, 2'b00};
      vecs[6] = '{9'h1FF, 10'd2,   8'h55, 1'b0, 2'b10};
      vecs[7] = '{9'h1FF, 10'h3FF, 8'h66, 1'b0, 2'b10};
      vecs[8] = '{9'h000, 10'd0,   8'hFF, 1'b0, 2'b01};

      rst_n    = 1'b0;
      usr_vld  = 1'b0;
      usr_data = '0;
      drdy     = 1'b0;
      erdy     = 1'b0;
      #3;
      chk("reset_usr_rdy", 64'(usr_rdy), 64'd0);
      chk("reset_dv", 64'(dv), 64'd0);
      chk("reset_ev", 64'(ev), 64'd0);
      chk("reset_ed", 64'(ed), 64'd0);
      chk("reset_cnt", 64'(cnt), 64'd0);
      chk("reset_rej", 64'(rej), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rdy_before_first_edge", 64'(usr_rdy), 64'd0);
      @(negedge clk);
      #1 chk("rdy_after_first_edge", 64'(usr_rdy), 64'd1);

      drdy = 1'b1;
      erdy = 1'b1;
      for (int i = 0; i < 9; i++) begin
         w = mk(vecs[i].udata, vecs[i].size, vecs[i].base);
         push_word(w);
         #1 chk($sformatf("v%0d_rdy", i), 64'(usr_rdy), 64'd1);
         @(negedge clk);
         usr_vld = 1'b0;
         if (!vecs[i].ok) rej_exp++;
         #1;
         chk($sformatf("v%0d_dv", i), 64'(dv), 64'(vecs[i].ok));
         chk($sformatf("v%0d_ev", i), 64'(ev), 64'(!vecs[i].ok));
         chk($sformatf("v%0d_rej", i), 64'(rej), 64'(rej_exp));
         if (vecs[i].ok)
            chk($sformatf("v%0d_dd", i), 64'(dd), 64'(w));
         else
            chk($sformatf("v%0d_ed", i), 64'(ed), 64'({vecs[i].udata, vecs[i].code}));
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_cnt_drained", i), 64'(cnt), 64'd0);
         chk($sformatf("v%0d_ev_cleared", i), 64'(ev), 64'd0);
      end

      // Back-pressure: five pushes, only four fit
      drdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push_word(mk(8'(8'h10 + k), 10'd1, 9'(k)));
         #1 chk($sformatf("fill%0d_rdy", k), 64'(usr_rdy), 64'(k < 4));
      end
      @(negedge clk);
      usr_vld = 1'b0;
      #1;
      chk("full_cnt", 64'(cnt), 64'd4);
      chk("full_rdy", 64'(usr_rdy), 64'd0);
      chk("full_head_stable", 64'(dd), 64'(mk(8'h10, 10'd1, 9'd0)));
      drdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("drain%0d_dv", k), 64'(dv), 64'd1);
         chk($sformatf("drain%0d_dd", k), 64'(dd), 64'(mk(8'(8'h10 + k), 10'd1, 9'(k))));
         @(negedge clk);
      end
      #1;
      chk("drain_cnt", 64'(cnt), 64'd0);
      chk("drain_dv", 64'(dv), 64'd0);

      // Simultaneous push and pop leaves the count unchanged
      drdy = 1'b0;
      push_word(mk(8'h70, 10'd4, 9'h020));
      @(negedge clk);
      #1 chk("pp_cnt_before", 64'(cnt), 64'd1);
      usr_data = mk(8'h71, 10'd4, 9'h040);
      drdy     = 1'b1;
      @(negedge clk);
      usr_vld = 1'b0;
      #1;
      chk("pp_cnt_after", 64'(cnt), 64'd1);
      chk("pp_head", 64'(dd), 64'(mk(8'h71, 10'd4, 9'h040)));
      @(negedge clk);
      #1 chk("pp_cnt_empty", 64'(cnt), 64'd0);

      // Error register stall, then replace on handshake
      erdy = 1'b0;
      wa   = mk(8'h51, 10'd0, 9'h000);
      wb   = mk(8'h62, 10'd2, 9'h1FF);
      push_word(wa);
      @(negedge clk);
      usr_data = wb;
      rej_exp++;
      #1;
      chk("err_a_vld", 64'(ev), 64'd1);
      chk("err_a_data", 64'(ed), 64'({8'h51, 2'b01}));
      chk("err_stall_rdy", 64'(usr_rdy), 64'd0);
      @(negedge clk);
      #1;
      chk("err_stall_data", 64'(ed), 64'({8'h51, 2'b01}));
      chk("err_stall_rej", 64'(rej), 64'(rej_exp));
      erdy = 1'b1;
      #1 chk("err_rdy_pass", 64'(usr_rdy), 64'd1);
      @(negedge clk);
      usr_vld = 1'b0;
      rej_exp++;
      #1;
      chk("err_b_vld", 64'(ev), 64'd1);
      chk("err_b_data", 64'(ed), 64'({8'h62, 2'b10}));
      chk("err_b_rej", 64'(rej), 64'(rej_exp));
      @(negedge clk);
      #1 chk("err_b_consumed", 64'(ev), 64'd0);

      // Asynchronous reset mid-operation
      drdy = 1'b0;
      erdy = 1'b0;
      for (int k = 0; k < 3; k++)
         push_word(mk(8'(8'h80 + k), 10'd8, 9'(16 * k)));
      push_word(mk(8'h90, 10'd0, 9'h000));
      @(negedge clk);
      usr_vld = 1'b0;
      #1;
      chk("pre_rst_cnt", 64'(cnt), 64'd3);
      chk("pre_rst_ev", 64'(ev), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_usr_rdy", 64'(usr_rdy), 64'd0);
      chk("rst_dv", 64'(dv), 64'd0);
      chk("rst_dd", 64'(dd), 64'd0);
      chk("rst_ev", 64'(ev), 64'd0);
      chk("rst_ed", 64'(ed), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_rej", 64'(rej), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drdy  = 1'b1;
      erdy  = 1'b1;
      #1 chk("rel_rdy_low", 64'(usr_rdy), 64'd0);
      @(negedge clk);
      #1;
      chk("rel_rdy_high", 64'(usr_rdy), 64'd1);
      chk("rel_dv", 64'(dv), 64'd0);
      chk("rel_ev", 64'(ev), 64'd0);
      push_word(mk(8'hC3, 10'd32, 9'h100));
      @(negedge clk);
      usr_vld = 1'b0;
      #1;
      chk("post_rst_dv", 64'(dv), 64'd1);
      chk("post_rst_dd", 64'(dd), 64'(mk(8'hC3, 10'd32, 9'h100)));
      @(negedge clk);
      #1 chk("post_rst_cnt", 64'(cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
